// File: rtl/f_res_buffer.sv
// f_res_buffer: result FIFO with issue-credit accounting behind a no-backpressure arithmetic pipeline
`ifndef FLEN
`define FLEN 64
`endif
module f_res_buffer #(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_issue,
  output logic             issue_ok,
  input  logic [`FLEN-1:0] fu_res,
  input  logic             fu_error,
  input  logic             fu_valid,
  output logic [`FLEN-1:0] res,
  output logic             res_error,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] inflight,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  logic [`FLEN:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] occ_q, occ_d, inf_q, inf_d;
  logic [CNT_W:0] used;
  logic ovf_q, ovf_d, full, push, pop, acc, ret;
  assign res_valid = occ_q != '0;
  assign {res_error, res} = res_valid ? mem_q[rd_q] : '0;
  assign occupancy = occ_q;
  assign inflight = inf_q;
  assign overflow = ovf_q;
  always_comb begin
    full = occ_q == FULL;
    pop = res_valid && res_ready;
    push = fu_valid && (!full || pop);
    used = {1'b0, inf_q} + {1'b0, occ_q};
    issue_ok = used < (CNT_W + 1)'(DEPTH);
    acc = up_issue && issue_ok;
    ret = fu_valid && inf_q != '0;
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    inf_d = inf_q + CNT_W'(acc) - CNT_W'(ret);
    ovf_d = ovf_q | (up_issue && !issue_ok) | (fu_valid && inf_q == '0) | (fu_valid && full && !pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      occ_q <= '0;
      inf_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      occ_q <= occ_d;
      inf_q <= inf_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_q] <= {fu_error, fu_res};
  end
endmodule

// File: tb/tb_f_res_buffer.sv
// tb_f_res_buffer: randomized and directed checks of f_res_buffer against a queue-based model
module tb_f_res_buffer;
  logic clk = 0, rst = 1, up_issue = 0, fu_error = 0, fu_valid = 0, res_ready = 0;
  logic [63:0] fu_res = '0;
  logic issue_ok, res_error, res_valid, overflow;
  logic [63:0] res;
  logic [2:0] occupancy, inflight;
  int compared = 0, mismatched = 0;
  logic [64:0] q[$];
  int infl = 0;
  bit ovf = 0;
  f_res_buffer dut (
    .clk(clk), .rst(rst), .up_issue(up_issue), .issue_ok(issue_ok),
    .fu_res(fu_res), .fu_error(fu_error), .fu_valid(fu_valid),
    .res(res), .res_error(res_error), .res_valid(res_valid), .res_ready(res_ready),
    .occupancy(occupancy), .inflight(inflight), .overflow(overflow)
  );
  always #5 clk = ~clk;
  function automatic logic [73:0] obs();
    return {issue_ok, res_valid, res, res_error, occupancy, inflight, overflow};
  endfunction
  function automatic logic [73:0] expv();
    logic [64:0] h;
    h = q.size() != 0 ? q[0] : 65'd0;
    return {(infl + q.size()) < 4, q.size() != 0, h[63:0], h[64], 3'(q.size()), 3'(infl), ovf};
  endfunction
  task automatic step(input bit r, input bit iss, input bit v, input bit e, input logic [63:0] d, input bit rdy);
    int sz;
    bit ok, pop, fits;
    rst = r; up_issue = iss; fu_valid = v; fu_error = e; fu_res = d; res_ready = rdy;
    @(posedge clk);
    if (r) begin
      q.delete(); infl = 0; ovf = 0;
    end else begin
      sz = q.size();
      ok = (infl + sz) < 4;
      pop = sz > 0 && rdy;
      fits = sz < 4 || pop;
      if (iss && !ok) ovf = 1;
      if (v && infl == 0) ovf = 1;
      if (v && !fits) ovf = 1;
      if (pop) void'(q.pop_front());
      if (v && fits) q.push_back({e, d});
      infl = infl + int'(iss && ok) - int'(v && infl != 0);
    end
    #1;
  endtask
  task automatic test_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    compared++;
    if (obs() !== expv()) begin mismatched++; $display("FAIL reset model got %h want %h", obs(), expv()); end
    compared++;
    if ({res_valid, issue_ok, occupancy, inflight, overflow, res} !== {1'b0, 1'b1, 3'd0, 3'd0, 1'b0, 64'd0}) begin
      mismatched++; $display("FAIL reset_const got v%b ok%b occ%0d inf%0d ovf%b res%h", res_valid, issue_ok, occupancy, inflight, overflow, res);
    end
  endtask
  task automatic test_single();
    step(0, 1, 0, 0, 0, 1);
    compared++;
    if (inflight !== 3'd1) begin mismatched++; $display("FAIL single_issue inflight got %0d want 1", inflight); end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 64'h3FF0000000000000, 1);
    compared++;
    if ({res_valid, res, inflight} !== {1'b1, 64'h3FF0000000000000, 3'd0}) begin
      mismatched++; $display("FAIL single_out got v%b res%h inf%0d want v1 res3ff0000000000000 inf0", res_valid, res, inflight);
    end
    step(0, 0, 0, 0, 0, 1);
    compared++;
    if ({res_valid, occupancy, res} !== {1'b0, 3'd0, 64'd0}) begin
      mismatched++; $display("FAIL single_drain got v%b occ%0d res%h want v0 occ0 res0", res_valid, occupancy, res);
    end
    compared++;
    if (obs() !== expv()) begin mismatched++; $display("FAIL single model got %h want %h", obs(), expv()); end
  endtask
  task automatic test_credit();
    logic [63:0] vals [4];
    vals[0] = 64'hA; vals[1] = 64'hB; vals[2] = 64'hC; vals[3] = 64'hD;
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    compared++;
    if ({issue_ok, inflight} !== {1'b0, 3'd4}) begin mismatched++; $display("FAIL credit_exhaust got ok%b inf%0d want ok0 inf4", issue_ok, inflight); end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, vals[i], 0);
    compared++;
    if ({occupancy, inflight, issue_ok, overflow} !== {3'd4, 3'd0, 1'b0, 1'b0}) begin
      mismatched++; $display("FAIL credit_full got occ%0d inf%0d ok%b ovf%b want occ4 inf0 ok0 ovf0", occupancy, inflight, issue_ok, overflow);
    end
    step(0, 1, 0, 0, 0, 0);
    compared++;
    if ({overflow, inflight} !== {1'b1, 3'd0}) begin mismatched++; $display("FAIL credit_violate got ovf%b inf%0d want ovf1 inf0", overflow, inflight); end
    for (int i = 0; i < 4; i++) begin
      compared++;
      if ({res_valid, res} !== {1'b1, vals[i]}) begin mismatched++; $display("FAIL credit_order%0d got v%b res%h want v1 res%h", i, res_valid, res, vals[i]); end
      step(0, 0, 0, 0, 0, 1);
    end
    compared++;
    if (obs() !== expv()) begin mismatched++; $display("FAIL credit model got %h want %h", obs(), expv()); end
  endtask
  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 64'h100 + 64'(i), 0);
    step(0, 0, 1, 0, 64'hE, 1);
    compared++;
    if ({occupancy, res, overflow} !== {3'd4, 64'h101, 1'b1}) begin
      mismatched++; $display("FAIL fullpp got occ%0d res%h ovf%b want occ4 res101 ovf1", occupancy, res, overflow);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1);
    compared++;
    if ({res_valid, res, occupancy} !== {1'b1, 64'hE, 3'd1}) begin mismatched++; $display("FAIL fullpp_tail got v%b res%h occ%0d want v1 resE occ1", res_valid, res, occupancy); end
    step(0, 0, 0, 0, 0, 1);
    compared++;
    if (obs() !== expv()) begin mismatched++; $display("FAIL fullpp model got %h want %h", obs(), expv()); end
  endtask
  task automatic test_error();
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 1, 64'h55, 0);
    compared++;
    if ({res_valid, res_error, res, overflow} !== {1'b1, 1'b1, 64'h55, 1'b0}) begin
      mismatched++; $display("FAIL err_flag got v%b e%b res%h ovf%b want v1 e1 res55 ovf0", res_valid, res_error, res, overflow);
    end
    step(0, 0, 1, 0, 64'h66, 0);
    compared++;
    if ({overflow, occupancy, inflight} !== {1'b1, 3'd2, 3'd0}) begin
      mismatched++; $display("FAIL spurious got ovf%b occ%0d inf%0d want ovf1 occ2 inf0", overflow, occupancy, inflight);
    end
    step(0, 0, 0, 0, 0, 1);
    compared++;
    if ({res, res_error} !== {64'h66, 1'b0}) begin mismatched++; $display("FAIL spurious_kept got res%h e%b want res66 e0", res, res_error); end
    step(0, 0, 0, 0, 0, 1);
    compared++;
    if (obs() !== expv()) begin mismatched++; $display("FAIL err model got %h want %h", obs(), expv()); end
  endtask
  task automatic test_reset_mid();
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 64'h77, 0);
    compared++;
    if ({inflight, occupancy} !== {3'd2, 3'd1}) begin mismatched++; $display("FAIL mid_setup got inf%0d occ%0d want inf2 occ1", inflight, occupancy); end
    step(1, 1, 1, 0, 64'h88, 1);
    compared++;
    if ({inflight, occupancy, res_valid, overflow, res} !== {3'd0, 3'd0, 1'b0, 1'b0, 64'd0}) begin
      mismatched++; $display("FAIL mid_reset got inf%0d occ%0d v%b ovf%b res%h want all 0", inflight, occupancy, res_valid, overflow, res);
    end
    step(0, 0, 0, 0, 0, 0);
    compared++;
    if (obs() !== expv()) begin mismatched++; $display("FAIL mid model got %h want %h", obs(), expv()); end
  endtask
  task automatic test_random();
    bit r, iss, v;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 79) == 0;
      iss = $urandom_range(0, 1) == 1;
      v = infl > 0 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 24) == 0;
      step(r, iss, v, $urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 3) != 0);
      compared++;
      if (obs() !== expv()) begin mismatched++; $display("FAIL random c%0d got %h want %h", i, obs(), expv()); end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_credit();
    test_full_pop_push();
    test_error();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/f_res_buffer.md
Name: f_res_buffer

Overview:
- Downstream stage of the fixed-latency floating-point arithmetic wrappers (f_add/f_sub/f_mult…). Those wrappers have no backpressure.
- Captures each {res, error} beat on its down_valid into a small FIFO and presents it to a valid/ready consumer.
- Counts results still in the arithmetic pipeline and grants issue credit upstream, so an accepted result can never be dropped.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding operations (power of two, >= 2).
- CNT_W, $clog2(DEPTH+1), width of the occupancy and in-flight counters (derived; not overridden).
- FLEN is the global width from config.vh; it is not a parameter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- up_issue  input  1  upstream drives the arithmetic block's up_valid this cycle.
- issue_ok  output  1  upstream may assert up_issue this cycle.
- fu_res  input  FLEN  result from the arithmetic block (res).
- fu_error  input  1  error flag from the arithmetic block.
- fu_valid  input  1  down_valid from the arithmetic block.
- res  output  FLEN  head-of-FIFO result.
- res_error  output  1  head-of-FIFO error flag.
- res_valid  output  1  head entry valid.
- res_ready  input  1  consumer accepts the head entry.
- occupancy  output  CNT_W  stored entries.
- inflight  output  CNT_W  issued operations whose results have not yet returned.
- overflow  output  1  sticky protocol-violation flag.

Behaviour:
Reset (sync, rst=1 at posedge):
- Pointers, occupancy, inflight and overflow go to 0; res_valid=0; res=0; res_error=0.
- rst has priority over every other event, including a mid-flight fu_valid or a pop.

Storage:
- DEPTH x (FLEN+1) register array, write and read pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
- res_valid = (occupancy != 0).
- res and res_error are driven from array[rd_ptr]. They read as 0 when the FIFO is empty (explicit mux, no stale data).

Push and pop:
- push = fu_valid && (occupancy < DEPTH || pop). Writes {fu_error, fu_res} at wr_ptr; wr_ptr++.
- pop = res_valid && res_ready. rd_ptr++.
- occupancy_next = occupancy + push - pop.
- Latency: fu_valid at edge N -> res_valid=1 with that data after edge N (visible in cycle N+1), provided the FIFO was empty.
- Full and simultaneous pop+push: both happen; occupancy stays DEPTH and the new data lands in the freed slot.
- Empty and simultaneous push: no bypass; pop cannot occur because res_valid=0.

Credit accounting:
- issue_ok is combinational: (inflight + occupancy) < DEPTH.
- A pop in the current cycle does not raise issue_ok until the next cycle.
- An accepted issue is up_issue && issue_ok.
- inflight_next = inflight + accepted_issue - (fu_valid && inflight != 0).

Overflow (sticky until rst):
- Set on up_issue && !issue_ok. That issue is not counted.
- Set on fu_valid && inflight == 0. The result is still pushed if there is space.
- Set on fu_valid while full with no pop. The result is dropped; pointers and occupancy are unchanged.

Invariants under legal use:
- inflight + occupancy <= DEPTH.
- Results leave in arrival order.

The arithmetic block's busy output is not an input here; upstream ANDs busy-free with issue_ok.

Test Plan:
- Reset/idle: hold rst 2 cycles -> res_valid=0, issue_ok=1, occupancy=0, inflight=0, overflow=0, res=0.
- Single op: up_issue 1 cycle (inflight->1), fu_valid 4 cycles later with fu_res=0x3FF0000000000000, fu_error=0, res_ready=1 -> res_valid for exactly 1 cycle with res=0x3FF0000000000000; inflight=0; occupancy=0.
- Credit exhaustion: res_ready=0, issue 4 ops -> issue_ok=0 after the 4th. Return results A, B, C, D -> occupancy=4. Attempt up_issue -> overflow=1, inflight stays 0. Then res_ready=1 -> A, B, C, D out in order, one per cycle.
- Full with simultaneous pop+push: occupancy=4 (after issue credit freed), res_ready=1 and fu_valid same cycle with value E -> occupancy stays 4, head advances, E appears after the remaining 3 entries, overflow unchanged.
- Error propagation and spurious result: fu_valid with fu_error=1 when inflight=1 -> res_error=1 on that entry. A further fu_valid with inflight=0 -> overflow=1 and the entry is still stored.
- Reset mid-operation: inflight=2, occupancy=1, fu_valid asserted in the rst cycle -> next cycle all counters 0, res_valid=0, overflow=0, nothing stored.
